// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register:
// default bundle widths, EX/MEM field layout and the skid occupancy states.
package pipe_pkg;

  // Default bundle widths (EX/MEM stage).
  localparam int CTRL_W_DEF = 4;
  localparam int DATA_W_DEF = 133;

  // EX/MEM control bundle layout: {regWrite, resultSrc[1:0], memWrite}.
  localparam int CTRL_REGWRITE_BIT  = 3;
  localparam int CTRL_RESULTSRC_LSB = 1;
  localparam int CTRL_RESULTSRC_W   = 2;
  localparam int CTRL_MEMWRITE_BIT  = 0;

  // EX/MEM payload layout: {ALUResult, writeData, rd, immExt, PCPlus4}.
  localparam int DATA_PCPLUS4_LSB   = 0;
  localparam int DATA_PCPLUS4_W     = 32;
  localparam int DATA_IMMEXT_LSB    = 32;
  localparam int DATA_IMMEXT_W      = 32;
  localparam int DATA_RD_LSB        = 64;
  localparam int DATA_RD_W          = 5;
  localparam int DATA_WRITEDATA_LSB = 69;
  localparam int DATA_WRITEDATA_W   = 32;
  localparam int DATA_ALURESULT_LSB = 101;
  localparam int DATA_ALURESULT_W   = 32;

  // Occupancy of the two-entry (main + skid) stage.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skidState_e;

  // Assemble an EX/MEM control bundle from its named fields.
  function automatic logic [3:0] exMemCtrl(input logic       regWrite,
                                           input logic [1:0] resultSrc,
                                           input logic       memWrite);
    return {regWrite, resultSrc, memWrite};
  endfunction

endpackage

// File: rtl/pipe_skid_slot.sv
// One {ctrl, data} holding register of the pipeline stage.
// clear zeroes only the control bits (bubble); the payload is kept so that
// downstream sees stable data, and only reset clears it.
module pipe_skid_slot
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] ctrlIn,
  input  logic [DATA_W-1:0] dataIn,
  output logic [CTRL_W-1:0] ctrlQ,
  output logic [DATA_W-1:0] dataQ
);

  // Slot storage: clear (bubble/flush) wins over load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrlQ <= {CTRL_W{1'b0}};
      dataQ <= {DATA_W{1'b0}};
    end else if (clear) begin
      ctrlQ <= {CTRL_W{1'b0}};
    end else if (load) begin
      ctrlQ <= ctrlIn;
      dataQ <= dataIn;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Elastic pipeline-stage register with valid/ready handshake, stall and
// synchronous flush. Empty or flushed stages present an all-zero control bubble.
// Build option: define PIPE_SKID_EN for a two-entry stage (main + skid) whose
// in_ready is a flop output; otherwise the stage holds a single entry and
// in_ready is combinational from out_ready.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data
);

  logic              accept;
  logic              emit;
  logic              mainLoad;
  logic              mainClear;
  logic [CTRL_W-1:0] mainCtrlIn;
  logic [DATA_W-1:0] mainDataIn;
  logic [CTRL_W-1:0] mainCtrl;
  logic [DATA_W-1:0] mainData;

`ifdef PIPE_SKID_EN

  skidState_e        stateR;
  skidState_e        stateNext;
  logic              inReadyR;
  logic              outValidR;
  logic              skidLoad;
  logic              skidClear;
  logic              mainFromSkid;
  logic [CTRL_W-1:0] skidCtrl;
  logic [DATA_W-1:0] skidData;

  assign in_ready   = inReadyR;
  assign out_valid  = outValidR;
  assign accept     = in_valid & inReadyR;
  assign emit       = outValidR & out_ready;
  assign mainCtrlIn = mainFromSkid ? skidCtrl : in_ctrl;
  assign mainDataIn = mainFromSkid ? skidData : in_data;

  // Occupancy register; in_ready and out_valid are decoded from the next state so both are flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateR    <= EMPTY;
      inReadyR  <= 1'b1;
      outValidR <= 1'b0;
    end else begin
      stateR    <= stateNext;
      inReadyR  <= (stateNext != TWO);
      outValidR <= (stateNext != EMPTY);
    end
  end

  // Next-state and slot steering; flush empties both slots and drops any same-cycle accept.
  always_comb begin
    stateNext    = stateR;
    mainLoad     = 1'b0;
    mainClear    = 1'b0;
    skidLoad     = 1'b0;
    skidClear    = 1'b0;
    mainFromSkid = 1'b0;
    if (flush) begin
      stateNext = EMPTY;
      mainClear = 1'b1;
      skidClear = 1'b1;
    end else begin
      case (stateR)
        EMPTY: begin
          if (accept) begin
            stateNext = ONE;
            mainLoad  = 1'b1;
          end else begin
            stateNext = EMPTY;
          end
        end
        ONE: begin
          if (accept && !emit) begin
            stateNext = TWO;
            skidLoad  = 1'b1;
          end else if (accept && emit) begin
            stateNext = ONE;
            mainLoad  = 1'b1;
          end else if (emit) begin
            stateNext = EMPTY;
            mainClear = 1'b1;
          end else begin
            stateNext = ONE;
          end
        end
        TWO: begin
          if (emit) begin
            stateNext    = ONE;
            mainLoad     = 1'b1;
            mainFromSkid = 1'b1;
            skidClear    = 1'b1;
          end else begin
            stateNext = TWO;
          end
        end
        default: begin
          stateNext = EMPTY;
          mainClear = 1'b1;
          skidClear = 1'b1;
        end
      endcase
    end
  end

  pipe_skid_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) uSkidSlot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (skidLoad),
    .clear  (skidClear),
    .ctrlIn (in_ctrl),
    .dataIn (in_data),
    .ctrlQ  (skidCtrl),
    .dataQ  (skidData)
  );

`else

  logic validR;

  assign out_valid  = validR;
  assign in_ready   = ~validR | out_ready;
  assign accept     = in_valid & in_ready;
  assign emit       = validR & out_ready;
  assign mainCtrlIn = in_ctrl;
  assign mainDataIn = in_data;

  // Valid flag of the single entry: flush > accept > emit > hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      validR <= 1'b0;
    end else if (flush) begin
      validR <= 1'b0;
    end else if (accept) begin
      validR <= 1'b1;
    end else if (emit) begin
      validR <= 1'b0;
    end else begin
      validR <= validR;
    end
  end

  // Slot steering: load on accept, bubble on flush or on a drain without refill.
  always_comb begin
    mainLoad  = 1'b0;
    mainClear = 1'b0;
    if (flush) begin
      mainClear = 1'b1;
    end else if (accept) begin
      mainLoad = 1'b1;
    end else if (emit) begin
      mainClear = 1'b1;
    end else begin
      mainLoad  = 1'b0;
      mainClear = 1'b0;
    end
  end

`endif

  pipe_skid_slot #(
    .CTRL_W(CTRL_W),
    .DATA_W(DATA_W)
  ) uMainSlot (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (mainLoad),
    .clear  (mainClear),
    .ctrlIn (mainCtrlIn),
    .dataIn (mainDataIn),
    .ctrlQ  (mainCtrl),
    .dataQ  (mainData)
  );

  assign out_ctrl = mainCtrl;
  assign out_data = mainData;

endmodule
